div_unit: RTL

//  - Iterative RV32M divider: DIV, DIVU, REM, REMU. It is the responder on the

---
 rtl/div_unit_if.sv | 27 ++
 rtl/div_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/div_unit_if.sv
// Request/response channel between the execute stage and the iterative divider.
//   req_valid/req_ready : request handshake carrying op, a (dividend), b (divisor)
//   op                  : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   resp_valid/resp_ready : response handshake carrying result
// master = execute stage (requester), slave = divider (responder).
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] result;

    modport master (
        output req_valid, op, a, b, resp_ready,
        input  req_ready, resp_valid, result
    );

    modport slave (
        input  req_valid, op, a, b, resp_ready,
        output req_ready, resp_valid, result
    );
endinterface

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV, DIVU, REM, REMU), radix-2 restoring, one
// quotient bit per clock.
//   clk   : clock, all state updates on posedge
//   rst   : synchronous reset, active-high (clears result too)
//   flush : abort any in-flight op; result is left unchanged
//   bus   : div_unit_if.slave request/response channel
// Divide-by-zero and signed overflow are resolved at accept and respond on the
// next edge; the normal path takes WIDTH iteration cycles after the accept edge.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    div_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               req_ready_reg;
    logic               resp_valid_reg;
    logic [WIDTH-1:0]   result_reg;
    logic [WIDTH-1:0]   dvd_reg;      // dividend magnitude, shifted out MSB first
    logic [WIDTH-1:0]   dvs_reg;      // divisor magnitude
    logic [WIDTH-1:0]   rem_reg;      // partial remainder (always < dvs after a step)
    logic [WIDTH-1:0]   quo_reg;      // quotient bits collected LSB-in
    logic               is_rem_reg;
    logic               neg_q_reg;
    logic               neg_r_reg;

    // Accept-time decode
    logic             accept;
    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             div_zero;
    logic             sgn_ovf;
    logic [WIDTH-1:0] special_result;

    // Iteration datapath
    logic [WIDTH:0]   rem_shift;      // one bit wider so the compare never overflows
    logic             rem_ge;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    always_comb begin
        accept    = bus.req_valid & req_ready_reg;
        op_signed = ~bus.op[0];
        a_neg     = op_signed & bus.a[WIDTH-1];
        b_neg     = op_signed & bus.b[WIDTH-1];
        a_abs     = a_neg ? (~bus.a + 1'b1) : bus.a;
        b_abs     = b_neg ? (~bus.b + 1'b1) : bus.b;
        div_zero  = (bus.b == '0);
        sgn_ovf   = op_signed & (bus.a == MIN_NEG) & (bus.b == '1);

        special_result = '0;
        if (div_zero) begin
            special_result = bus.op[1] ? bus.a : '1;
        end else if (sgn_ovf) begin
            special_result = bus.op[1] ? '0 : MIN_NEG;
        end

        rem_shift = {rem_reg, dvd_reg[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, dvs_reg});
        rem_step  = rem_ge ? (rem_shift - {1'b0, dvs_reg}) : rem_shift;
        quo_step  = {quo_reg[WIDTH-2:0], rem_ge};

        q_final = neg_q_reg ? (~quo_step + 1'b1) : quo_step;
        r_final = neg_r_reg ? (~rem_step[WIDTH-1:0] + 1'b1) : rem_step[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            result_reg     <= '0;
            dvd_reg        <= '0;
            dvs_reg        <= '0;
            rem_reg        <= '0;
            quo_reg        <= '0;
            is_rem_reg     <= 1'b0;
            neg_q_reg      <= 1'b0;
            neg_r_reg      <= 1'b0;
        end else if (flush) begin
            state_reg      <= S_IDLE;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        req_ready_reg <= 1'b0;
                        is_rem_reg    <= bus.op[1];
                        neg_q_reg     <= a_neg ^ b_neg;
                        neg_r_reg     <= a_neg;
                        if (div_zero || sgn_ovf) begin
                            result_reg     <= special_result;
                            resp_valid_reg <= 1'b1;
                            state_reg      <= S_DONE;
                        end else begin
                            dvd_reg   <= a_abs;
                            dvs_reg   <= b_abs;
                            rem_reg   <= '0;
                            quo_reg   <= '0;
                            cnt_reg   <= '0;
                            state_reg <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    dvd_reg <= {dvd_reg[WIDTH-2:0], 1'b0};
                    rem_reg <= rem_step[WIDTH-1:0];
                    quo_reg <= quo_step;
                    if (cnt_reg == CNT_W'(WIDTH-1)) begin
                        result_reg     <= is_rem_reg ? r_final : q_final;
                        resp_valid_reg <= 1'b1;
                        state_reg      <= S_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        req_ready_reg  <= 1'b1;
                        state_reg      <= S_IDLE;
                    end
                end
                default: begin
                    state_reg      <= S_IDLE;
                    req_ready_reg  <= 1'b1;
                    resp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_reg;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.result     = result_reg;
endmodule
